regfile_multiport: RTL and testbench
====================================

# regfile_multiport

Parametrised RISC-V integer register file with `NRD` read ports and one write port, plus a handshaked serial dump port. It sits between decode, writeback and the datapath debug/observation logic. It replaces the 32 parallel per-register output buses with a single streamed dump interface. It adds write-to-read bypass and a configurable read-port count.

## Interface
Parameters:
- `XLEN`, 32, register width in bits
- `NREGS`, 32, number of architectural registers; power of two, ≥ 4
- `NRD`, 2, number of read ports, 1..4
- `AW`, `$clog2(NREGS)`, derived address width; not overridden

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `rd_addr`  in  `NRD*AW`  read addresses; port k uses bits `[k*AW +: AW]`
- `rd_data`  out  `NRD*XLEN`  registered read data; port k uses bits `[k*XLEN +: XLEN]`
- `wr_en`  in  1  write enable from the controller
- `wr_addr`  in  `AW`  destination register
- `wr_data`  in  `XLEN`  writeback value
- `dump_start`  in  1  request a full register dump
- `dump_busy`  out  1  dump in progress
- `dump_valid`  out  1  `dump_idx`/`dump_data` are valid
- `dump_ready`  in  1  consumer accepts the current beat
- `dump_idx`  out  `AW`  register index of the current beat
- `dump_data`  out  `XLEN`  register value of the current beat
- `dump_last`  out  1  current beat is index `NREGS-1`

## Operation
- Register 0 is hardwired to zero. Writes to address 0 are dropped. Reads of address 0 return 0.
- Reset values come from the package:
  - x1 = 7, x2 = 7, x29 = 252
  - all other registers = 0
- A write with `wr_en=1` and `wr_addr≠0` commits at the clock edge.
- Read port k, each edge: `rd_data[k] <= (wr_en && wr_addr==rd_addr[k] && wr_addr≠0) ? wr_data : regs[rd_addr[k]]`. This is write-first bypass.
- Dump FSM has two states, IDLE and RUN.
- IDLE:
  - `dump_start=1` at an edge → RUN, with `dump_idx=0` and `dump_data` loaded.
- RUN:
  - A beat transfers on the edge where `dump_valid && dump_ready`.
  - On transfer with `dump_idx<NREGS-1`: increment `dump_idx` and load the next value.
  - On transfer with `dump_last=1`: return to IDLE.
- `dump_data` is a register. It is loaded with the same write-first bypass rule used by the read ports.
- `dump_data` stays stable while `dump_valid && !dump_ready`, even if the presented register is written meanwhile.
- `dump_start` is ignored while in RUN, including the final-beat cycle.
- `dump_busy = dump_valid` = (state==RUN).
- `dump_last = (state==RUN) && dump_idx==NREGS-1`.

## Timing
- After a reset edge:
  - `rd_data` = 0, `dump_valid` = 0, `dump_busy` = 0, `dump_last` = 0
  - `dump_idx` = 0, `dump_data` = 0, state = IDLE
  - register array holds its reset values
- Reset asserted mid-dump aborts the dump. Outputs take their reset values at that edge, and no further beats are produced.
- Reset has priority over a simultaneous write. The write is lost.
- Read latency is 1 cycle: `rd_addr` sampled at edge N appears on `rd_data` after edge N.
- Write latency is 1 cycle. A write at edge N is visible through the array from edge N+1. Via bypass it is visible to a read sampled at the same edge N.
- Dump timing:
  - `dump_start` at edge N → `dump_valid=1` after N.
  - With `dump_ready` held high, one beat per cycle; `NREGS` beats over edges N+1 .. N+NREGS.
  - `dump_valid=0` after edge N+NREGS.
- Simultaneous read and dump of the same register see the same value.

## Structure
- Package `regfile_pkg` holds:
  - default `XLEN`/`NREGS`
  - function `reg_reset_value(idx)` returning the x1/x2/x29 constants
  - dump state enum `{DUMP_IDLE, DUMP_RUN}`
- Sub-module `regfile_dump_ctrl` contains the FSM, index counter and `last` flag. It outputs the dump address and a load strobe. The top instantiates it and muxes the array with bypass.
- Read ports are built with a generate loop over `NRD`.

## Test plan
- Reset then read ports 0/1 at x1/x29 → `rd_data` 7 and 252 one cycle later; read of x0 → 0.
- `wr_en=1`, `wr_addr=5`, `wr_data=0xDEADBEEF`, with `rd_addr[0]=5` in the same cycle → `rd_data[0]=0xDEADBEEF` after that edge (bypass). Write to x0 with 0x1234 → reads of x0 stay 0.
- `dump_start` pulse with `dump_ready=1` → 32 consecutive beats, idx 0..31, with data matching reset values; `dump_last` only on idx 31; then `dump_valid=0`.
- During a dump, hold `dump_ready=0` at idx 3 and write x3=0x55 → `dump_data` stays 0 until the transfer. A later dump shows x3=0x55.
- Assert `reset` at dump idx 10 → `dump_valid=0` next cycle and registers back to reset values. `dump_start` at the last-beat edge → ignored, state IDLE.
- With `NRD=3`, `NREGS=16`, `XLEN=16`: write x15=0xFFFF, then read on all ports → all 0xFFFF. Dump → 16 beats, `dump_last` at idx 15.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants, dump FSM state type and architectural reset values for the register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   typedef enum logic {DUMP_IDLE, DUMP_RUN} dump_state_e;

   // Architectural reset value of register idx; x0 and unlisted registers start at zero
   function automatic logic [31:0] reg_reset_value(input int unsigned idx);
      case (idx)
         1, 2:    return 32'd7;
         29:      return 32'd252;
         default: return 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// Bundle of read, write and dump signals between the pipeline/debug logic and the register file.
// Latency: n/a (wires only).
// Backpressure: dump_ready from the consumer holds the current dump beat.
interface regfile_multiport_if
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = 2
);
   localparam int AW = $clog2(NREGS);

   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic                dump_start;
   logic                dump_busy;
   logic                dump_valid;
   logic                dump_ready;
   logic [AW-1:0]       dump_idx;
   logic [XLEN-1:0]     dump_data;
   logic                dump_last;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, dump_start, dump_ready,
      input  rd_data, dump_busy, dump_valid, dump_idx, dump_data, dump_last
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, dump_start, dump_ready,
      output rd_data, dump_busy, dump_valid, dump_idx, dump_data, dump_last
   );

endinterface

// File: rtl/regfile_dump_ctrl.sv
// Dump sequencer: walks register indices 0..NREGS-1, one beat per accepted handshake.
// Latency: first beat valid one cycle after start; then one beat per cycle while ready.
// Backpressure: index and load strobe freeze while ready_i is low; start ignored while running.
module regfile_dump_ctrl
   import regfile_pkg::*;
#(
   parameter int NREGS = NREGS_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start_i,
   input  logic                     ready_i,
   output logic                     valid_o,
   output logic                     last_o,
   output logic [$clog2(NREGS)-1:0] idx_o,
   output logic                     load_o,
   output logic [$clog2(NREGS)-1:0] load_addr_o
);
   localparam int AW = $clog2(NREGS);
   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   dump_state_e   state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;

   // State and index registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= DUMP_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Next state; load strobe tells the top which register to capture into the beat register
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      load_o      = 1'b0;
      load_addr_o = idx_q;
      case (state_q)
         DUMP_IDLE: begin
            if (start_i) begin
               state_d     = DUMP_RUN;
               idx_d       = '0;
               load_o      = 1'b1;
               load_addr_o = '0;
            end
         end
         DUMP_RUN: begin
            if (ready_i) begin
               if (idx_q == LAST_IDX) begin
                  state_d = DUMP_IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d       = idx_q + AW'(1);
                  load_o      = 1'b1;
                  load_addr_o = idx_q + AW'(1);
               end
            end
         end
         default: state_d = DUMP_IDLE;
      endcase
   end

   assign valid_o = (state_q == DUMP_RUN);
   assign last_o  = valid_o && (idx_q == LAST_IDX);
   assign idx_o   = idx_q;

endmodule

// File: rtl/regfile_multiport.sv
// Integer register file: NRD registered read ports, one write port, streamed register dump.
// Latency: reads and dump beats one cycle after sampling, with write-first bypass.
// Backpressure: dump beat held stable while dump_ready is low; reads/writes never stall.
module regfile_multiport
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = 2
) (
   input logic                clk,
   input logic                reset,
   regfile_multiport_if.slave bus
);
   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   logic [XLEN-1:0] dump_data_q, dump_data_d;
   logic            wr_commit;
   logic            dump_load;
   logic [AW-1:0]   dump_addr;

   // x0 is never written, so it stays at its zero reset value and reads return 0
   assign wr_commit = bus.wr_en && (bus.wr_addr != '0);

   // Array next state: single write port
   always_comb begin
      regs_d = regs_q;
      if (wr_commit) regs_d[bus.wr_addr] = bus.wr_data;
   end

   // Array storage; reset wins over a simultaneous write
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= XLEN'(reg_reset_value(i));
      end else begin
         regs_q <= regs_d;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] rd_data_d, rd_data_q;

      assign addr = bus.rd_addr[k*AW +: AW];

      // Write-first read: a same-cycle write to this address is forwarded
      always_comb rd_data_d = (wr_commit && bus.wr_addr == addr) ? bus.wr_data : regs_q[addr];

      // Registered read data
      always_ff @(posedge clk) begin
         if (reset) rd_data_q <= '0;
         else       rd_data_q <= rd_data_d;
      end

      assign bus.rd_data[k*XLEN +: XLEN] = rd_data_q;
   end

   regfile_dump_ctrl #(.NREGS(NREGS)) u_dump_ctrl (
      .clk         (clk),
      .reset       (reset),
      .start_i     (bus.dump_start),
      .ready_i     (bus.dump_ready),
      .valid_o     (bus.dump_valid),
      .last_o      (bus.dump_last),
      .idx_o       (bus.dump_idx),
      .load_o      (dump_load),
      .load_addr_o (dump_addr)
   );

   // Beat register: captured only on start or transfer, so a stalled beat never changes
   always_comb begin
      dump_data_d = dump_data_q;
      if (dump_load) begin
         dump_data_d = (wr_commit && bus.wr_addr == dump_addr) ? bus.wr_data : regs_q[dump_addr];
      end
   end

   // Beat data register
   always_ff @(posedge clk) begin
      if (reset) dump_data_q <= '0;
      else       dump_data_q <= dump_data_d;
   end

   assign bus.dump_data = dump_data_q;
   assign bus.dump_busy = bus.dump_valid;

endmodule

// File: tb/tb_regfile_multiport.sv
module tb_regfile_multiport;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   regfile_multiport_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus_a ();
   regfile_multiport_if #(.XLEN(16), .NREGS(16), .NRD(3)) bus_b ();

   regfile_multiport #(.XLEN(32), .NREGS(32), .NRD(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   regfile_multiport #(.XLEN(16), .NREGS(16), .NRD(3)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

   int checks = 0;
   int errors = 0;

   logic [31:0] ma [32];
   logic [15:0] mb [16];
   logic [31:0] exp_a [2];
   logic [15:0] exp_b [3];
   logic [4:0]  ra;
   logic [3:0]  rb;
   logic [31:0] held;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_models();
      for (int i = 0; i < 32; i++) ma[i] = 32'd0;
      for (int i = 0; i < 16; i++) mb[i] = 16'd0;
      ma[1] = 32'd7; ma[2] = 32'd7; ma[29] = 32'd252;
      mb[1] = 16'd7; mb[2] = 16'd7;
   endtask

   task automatic check_beat_a(input int i);
      check($sformatf("a_dump_valid[%0d]", i), bus_a.dump_valid, 1);
      check($sformatf("a_dump_busy[%0d]", i), bus_a.dump_busy, 1);
      check($sformatf("a_dump_idx[%0d]", i), bus_a.dump_idx, i);
      check($sformatf("a_dump_data[%0d]", i), bus_a.dump_data, ma[i]);
      check($sformatf("a_dump_last[%0d]", i), bus_a.dump_last, (i == 31) ? 1 : 0);
   endtask

   initial begin
      reset = 1'b1;
      bus_a.rd_addr = '0; bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
      bus_a.dump_start = 1'b0; bus_a.dump_ready = 1'b1;
      bus_b.rd_addr = '0; bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
      bus_b.dump_start = 1'b0; bus_b.dump_ready = 1'b1;
      reset_models();

      // Reset state
      step();
      check("rst_a_rd_data", bus_a.rd_data, 0);
      check("rst_b_rd_data", bus_b.rd_data, 0);
      check("rst_a_dump_valid", bus_a.dump_valid, 0);
      check("rst_a_dump_busy", bus_a.dump_busy, 0);
      check("rst_a_dump_last", bus_a.dump_last, 0);
      check("rst_a_dump_idx", bus_a.dump_idx, 0);
      check("rst_a_dump_data", bus_a.dump_data, 0);
      reset = 1'b0;

      // Reset values through the read ports
      bus_a.rd_addr = {5'd29, 5'd1};
      bus_b.rd_addr = {4'd0, 4'd2, 4'd1};
      step();
      check("rd_x1", bus_a.rd_data[31:0], 32'd7);
      check("rd_x29", bus_a.rd_data[63:32], 32'd252);
      check("b_rd_x1", bus_b.rd_data[15:0], 16'd7);
      check("b_rd_x2", bus_b.rd_data[31:16], 16'd7);
      check("b_rd_x0", bus_b.rd_data[47:32], 16'd0);
      bus_a.rd_addr = {5'd2, 5'd0};
      step();
      check("rd_x0", bus_a.rd_data[31:0], 32'd0);
      check("rd_x2", bus_a.rd_data[63:32], 32'd7);

      // Write-first bypass, then x0 write dropped
      bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd5; bus_a.wr_data = 32'hDEADBEEF;
      bus_a.rd_addr = {5'd29, 5'd5};
      step();
      ma[5] = 32'hDEADBEEF;
      check("bypass_x5", bus_a.rd_data[31:0], 32'hDEADBEEF);
      check("bypass_other_port", bus_a.rd_data[63:32], 32'd252);
      bus_a.wr_addr = 5'd0; bus_a.wr_data = 32'h1234;
      bus_a.rd_addr = {5'd5, 5'd0};
      step();
      check("x0_write_bypass", bus_a.rd_data[31:0], 32'd0);
      check("x5_from_array", bus_a.rd_data[63:32], 32'hDEADBEEF);
      bus_a.wr_en = 1'b0;
      step();
      check("x0_after_write", bus_a.rd_data[31:0], 32'd0);

      // Randomized reads/writes on both configurations against the array model
      for (int c = 0; c < 300; c++) begin
         bus_a.wr_en = ($urandom_range(0, 2) != 0);
         bus_a.wr_addr = 5'($urandom_range(0, 31));
         bus_a.wr_data = $urandom;
         for (int k = 0; k < 2; k++) begin
            ra = ($urandom_range(0, 3) == 0) ? bus_a.wr_addr : 5'($urandom_range(0, 31));
            bus_a.rd_addr[k*5 +: 5] = ra;
            exp_a[k] = (bus_a.wr_en && ra == bus_a.wr_addr && ra != 5'd0) ? bus_a.wr_data : ma[ra];
         end
         bus_b.wr_en = ($urandom_range(0, 2) != 0);
         bus_b.wr_addr = 4'($urandom_range(0, 15));
         bus_b.wr_data = 16'($urandom);
         for (int k = 0; k < 3; k++) begin
            rb = ($urandom_range(0, 3) == 0) ? bus_b.wr_addr : 4'($urandom_range(0, 15));
            bus_b.rd_addr[k*4 +: 4] = rb;
            exp_b[k] = (bus_b.wr_en && rb == bus_b.wr_addr && rb != 4'd0) ? bus_b.wr_data : mb[rb];
         end
         step();
         for (int k = 0; k < 2; k++)
            check($sformatf("rand_a[%0d].p%0d", c, k), bus_a.rd_data[k*32 +: 32], exp_a[k]);
         for (int k = 0; k < 3; k++)
            check($sformatf("rand_b[%0d].p%0d", c, k), bus_b.rd_data[k*16 +: 16], exp_b[k]);
         if (bus_a.wr_en && bus_a.wr_addr != 5'd0) ma[bus_a.wr_addr] = bus_a.wr_data;
         if (bus_b.wr_en && bus_b.wr_addr != 4'd0) mb[bus_b.wr_addr] = bus_b.wr_data;
      end

      // Reset beats a simultaneous write
      bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd5; bus_a.wr_data = 32'hAAAA5555;
      bus_b.wr_en = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      reset_models();
      bus_a.wr_en = 1'b0;
      bus_a.rd_addr = {5'd1, 5'd5};
      step();
      check("rst_beats_write_x5", bus_a.rd_data[31:0], 32'd0);
      check("rst_restores_x1", bus_a.rd_data[63:32], 32'd7);

      // Small configuration: write x15, read on all ports (bypass then array)
      bus_b.wr_en = 1'b1; bus_b.wr_addr = 4'd15; bus_b.wr_data = 16'hFFFF;
      bus_b.rd_addr = {4'd15, 4'd15, 4'd15};
      step();
      mb[15] = 16'hFFFF;
      bus_b.wr_en = 1'b0;
      for (int k = 0; k < 3; k++) check($sformatf("b_x15_bypass_p%0d", k), bus_b.rd_data[k*16 +: 16], 16'hFFFF);
      step();
      for (int k = 0; k < 3; k++) check($sformatf("b_x15_array_p%0d", k), bus_b.rd_data[k*16 +: 16], 16'hFFFF);

      // Full dumps on both, ready held high; start at A's last-beat edge must be ignored
      bus_a.dump_start = 1'b1; bus_b.dump_start = 1'b1;
      step();
      bus_a.dump_start = 1'b0; bus_b.dump_start = 1'b0;
      for (int i = 0; i < 32; i++) begin
         check_beat_a(i);
         if (i < 16) begin
            check($sformatf("b_dump_valid[%0d]", i), bus_b.dump_valid, 1);
            check($sformatf("b_dump_idx[%0d]", i), bus_b.dump_idx, i);
            check($sformatf("b_dump_data[%0d]", i), bus_b.dump_data, mb[i]);
            check($sformatf("b_dump_last[%0d]", i), bus_b.dump_last, (i == 15) ? 1 : 0);
         end else begin
            check($sformatf("b_dump_done[%0d]", i), bus_b.dump_valid, 0);
         end
         if (i == 31) bus_a.dump_start = 1'b1;
         step();
         bus_a.dump_start = 1'b0;
      end
      check("a_dump_end_valid", bus_a.dump_valid, 0);
      check("a_dump_end_busy", bus_a.dump_busy, 0);
      check("a_dump_end_last", bus_a.dump_last, 0);
      step();
      check("a_start_on_last_ignored", bus_a.dump_valid, 0);

      // Stall at idx 3 while x3 is written: held beat keeps the old value
      bus_a.dump_start = 1'b1;
      step();
      bus_a.dump_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_beat_a(i);
         step();
      end
      check_beat_a(3);
      held = ma[3];
      bus_a.dump_ready = 1'b0;
      bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd3; bus_a.wr_data = 32'h55;
      step();
      bus_a.wr_en = 1'b0;
      ma[3] = 32'h55;
      check("stall_idx", bus_a.dump_idx, 3);
      check("stall_valid", bus_a.dump_valid, 1);
      check("stall_data_1", bus_a.dump_data, held);
      step();
      check("stall_data_2", bus_a.dump_data, held);
      check("stall_idx_2", bus_a.dump_idx, 3);
      bus_a.dump_ready = 1'b1;
      step();
      for (int i = 4; i < 32; i++) begin
         check_beat_a(i);
         step();
      end
      check("stall_dump_end", bus_a.dump_valid, 0);

      // Second dump shows the new x3; reset at idx 10 aborts it
      bus_a.dump_start = 1'b1;
      step();
      bus_a.dump_start = 1'b0;
      for (int i = 0; i <= 10; i++) begin
         check_beat_a(i);
         if (i < 10) step();
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      reset_models();
      check("abort_valid", bus_a.dump_valid, 0);
      check("abort_busy", bus_a.dump_busy, 0);
      check("abort_last", bus_a.dump_last, 0);
      check("abort_idx", bus_a.dump_idx, 0);
      check("abort_data", bus_a.dump_data, 0);
      bus_a.rd_addr = {5'd29, 5'd3};
      step();
      check("abort_no_beats_1", bus_a.dump_valid, 0);
      check("abort_x3_reset", bus_a.rd_data[31:0], ma[3]);
      check("abort_x29_reset", bus_a.rd_data[63:32], ma[29]);
      step();
      check("abort_no_beats_2", bus_a.dump_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
